// File: rtl/cam_stim_pkg.sv
// Shared encodings and helpers for the camera-side stimulus generator.
package cam_stim_pkg;

  // Data pattern selection, latched once per frame
  typedef enum logic [1:0] {
    MODE_CONST  = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BARS   = 2'd3
  } cam_mode_e;

  // Frame sequencer state
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cam_state_e;

  // RGB444 colour bar byte: even byte carries {0,R}, odd byte carries {G,B}.
  // Bar index bits map to R (bit 2), G (bit 1), B (bit 0) at full intensity.
  function automatic logic [7:0] bar_byte(input logic [2:0] bar, input logic odd);
    logic [3:0] r, g, b;
    r = bar[2] ? 4'hF : 4'h0;
    g = bar[1] ? 4'hF : 4'h0;
    b = bar[0] ? 4'hF : 4'h0;
    return odd ? {g, b} : {4'h0, r};
  endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// Registered pixel byte generator. Loads a new byte on each emitted slot,
// zero outside HREF, and clears when the sequencer idles.
module cam_pattern_gen
  import cam_stim_pkg::*;
#(
  parameter logic [7:0] CONST_VAL = 8'h0F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emit,
  input  logic       clear,
  input  logic       href,
  input  logic [1:0] mode,
  input  logic [7:0] col,
  input  logic [2:0] bar,
  output logic [7:0] px_data
);

  // Byte register, updated only when the sequencer emits a slot
  always_ff @(posedge clk) begin
    if (rst) begin
      px_data <= 8'h00;
    end else if (emit) begin
      if (!href) begin
        px_data <= 8'h00;
      end else begin
        case (mode)
          MODE_CONST:  px_data <= CONST_VAL;
          MODE_TOGGLE: px_data <= col[2] ? ~CONST_VAL : CONST_VAL;
          MODE_COUNT:  px_data <= col;
          default:     px_data <= bar_byte(bar, col[0]);
        endcase
      end
    end else if (clear) begin
      px_data <= 8'h00;
    end
  end

endmodule

// File: rtl/cam_stim_gen.sv
// OV7670-style camera byte stream generator: PCLK divider, frame/line
// sequencing and sync generation. Outputs change only on PCLK falling edges.
module cam_stim_gen
  import cam_stim_pkg::*;
#(
  parameter int         LINE_BYTES = 320,
  parameter int         ROWS       = 120,
  parameter int         H_BLANK    = 4,
  parameter int         V_BLANK    = 4,
  parameter int         VSYNC_ROWS = 2,
  parameter int         PCLK_HALF  = 2,
  parameter logic [7:0] CONST_VAL  = 8'h0F,
  parameter int         BAR_W      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  output logic        CAM_PCLK,
  output logic        CAM_VSYNC,
  output logic        CAM_HREF,
  output logic [7:0]  CAM_px_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int COLS  = LINE_BYTES + H_BLANK;
  localparam int TROWS = V_BLANK + ROWS;
  localparam int COL_W = $clog2(COLS  > 1 ? COLS  : 2);
  localparam int ROW_W = $clog2(TROWS > 1 ? TROWS : 2);
  localparam int DIV_W = $clog2(PCLK_HALF > 1 ? PCLK_HALF : 2);
  localparam int PIX_W = $clog2(BAR_W > 1 ? BAR_W : 2);

  logic [DIV_W-1:0] div_cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PIX_W-1:0] pix_in_bar;
  logic [2:0]       bar;
  logic [1:0]       mode_q;
  cam_state_e       state;

  logic       div_end, fall_ev, emit, clear;
  logic       last_col, last_row;
  logic       slot_vsync, slot_href;
  logic [1:0] slot_mode;
  logic [7:0] col8;

  assign div_end    = (div_cnt == DIV_W'(PCLK_HALF - 1));
  // The clk on which the registered PCLK goes 1->0
  assign fall_ev    = div_end && CAM_PCLK;
  // A frame (re)starts from IDLE only if enable is high at that fall event
  assign emit       = fall_ev && ((state == RUN) || enable);
  assign clear      = fall_ev && (state == IDLE) && !enable;
  assign last_col   = (col == COL_W'(COLS - 1));
  assign last_row   = (row == ROW_W'(TROWS - 1));
  assign slot_vsync = (row < ROW_W'(VSYNC_ROWS));
  assign slot_href  = (row >= ROW_W'(V_BLANK)) && (col < COL_W'(LINE_BYTES));
  // On the starting slot the fresh mode must be used, not the stale latch
  assign slot_mode  = (state == IDLE) ? mode : mode_q;
  assign col8       = 8'(col);

  // Free-running PCLK divider, active in both IDLE and RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      CAM_PCLK <= 1'b0;
    end else if (div_end) begin
      div_cnt  <= '0;
      CAM_PCLK <= ~CAM_PCLK;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Frame sequencer: slot counters, bar tracking, syncs and frame accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 2'd0;
      col        <= '0;
      row        <= '0;
      pix_in_bar <= '0;
      bar        <= 3'd0;
      CAM_VSYNC  <= 1'b0;
      CAM_HREF   <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      if (clear) begin
        CAM_VSYNC <= 1'b0;
        CAM_HREF  <= 1'b0;
      end
      if (emit) begin
        if (state == IDLE) begin
          mode_q <= mode;
          state  <= RUN;
        end
        CAM_VSYNC <= slot_vsync;
        CAM_HREF  <= slot_href;
        if (last_col) begin
          col        <= '0;
          pix_in_bar <= '0;
          bar        <= 3'd0;
          if (last_row) begin
            // Last slot of the frame: the next fall event decides RUN vs IDLE
            row        <= '0;
            state      <= IDLE;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
          end else begin
            row <= row + ROW_W'(1);
          end
        end else begin
          col <= col + COL_W'(1);
          // Pixel boundary after each odd byte; step the bar every BAR_W pixels
          if (col[0]) begin
            if (pix_in_bar == PIX_W'(BAR_W - 1)) begin
              pix_in_bar <= '0;
              bar        <= bar + 3'd1;
            end else begin
              pix_in_bar <= pix_in_bar + PIX_W'(1);
            end
          end
        end
      end
    end
  end

  cam_pattern_gen #(
    .CONST_VAL (CONST_VAL)
  ) u_pat (
    .clk     (clk),
    .rst     (rst),
    .emit    (emit),
    .clear   (clear),
    .href    (slot_href),
    .mode    (slot_mode),
    .col     (col8),
    .bar     (bar),
    .px_data (CAM_px_data)
  );

endmodule

// File: tb/tb_cam_stim_gen.sv
// Bench for cam_stim_gen: reduced frame geometry, a slot-level reference
// model, table-driven pattern checks, corner-case sequences, random stimulus.
module tb_cam_stim_gen;

  localparam int         LB = 64, NR = 3, HB = 4, VB = 4, VS = 2, PH = 2, BW = 4;
  localparam logic [7:0] CV = 8'h0F;
  localparam int         C  = LB + HB;
  localparam int         TR = VB + NR;
  localparam int         FRAME_CLK = C * TR * 2 * PH;
  localparam int         FB = FRAME_CLK + 64;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        CAM_PCLK, CAM_VSYNC, CAM_HREF, frame_done;
  logic [7:0]  CAM_px_data;
  logic [15:0] frame_cnt;

  cam_stim_gen #(
    .LINE_BYTES(LB), .ROWS(NR), .H_BLANK(HB), .V_BLANK(VB),
    .VSYNC_ROWS(VS), .PCLK_HALF(PH), .CONST_VAL(CV), .BAR_W(BW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .CAM_PCLK(CAM_PCLK), .CAM_VSYNC(CAM_VSYNC), .CAM_HREF(CAM_HREF),
    .CAM_px_data(CAM_px_data), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected byte for a slot, straight from the pattern rules
  function automatic logic [7:0] ref_byte(input int md, input int r, input int c);
    int bar;
    logic [3:0] rr, gg, bb;
    if (r < VB || c >= LB) return 8'h00;
    case (md)
      0: return CV;
      1: return (((c / 4) % 2) == 1) ? ~CV : CV;
      2: return 8'(c % 256);
      default: begin
        bar = ((c / 2) / BW) % 8;
        rr = (bar >= 4)           ? 4'hF : 4'h0;
        gg = (((bar / 2) % 2) == 1) ? 4'hF : 4'h0;
        bb = ((bar % 2) == 1)       ? 4'hF : 4'h0;
        return ((c % 2) == 1) ? {gg, bb} : {4'h0, rr};
      end
    endcase
  endfunction

  // Reference model state
  int          m_n, m_row, m_col, m_mode, m_er, m_ec;
  bit          m_run, m_emit;
  logic        m_pclk, m_vs, m_hr, m_fd;
  logic [7:0]  m_px;
  logic [15:0] m_fc;
  logic [7:0]  cap [TR][C];

  // Advance the model by one clk using the inputs present at that edge
  task automatic model_step();
    m_emit = 0;
    m_fd   = 1'b0;
    if (rst) begin
      m_n = 0; m_run = 0; m_row = 0; m_col = 0; m_mode = 0;
      m_vs = 1'b0; m_hr = 1'b0; m_px = 8'h00; m_fc = 16'h0; m_pclk = 1'b0;
    end else begin
      m_n++;
      m_pclk = ((m_n / PH) % 2) == 1;
      if ((m_n % (2 * PH)) == 0) begin
        if (!m_run && !enable) begin
          m_vs = 1'b0; m_hr = 1'b0; m_px = 8'h00;
        end else begin
          if (!m_run) begin m_run = 1; m_mode = int'(mode); end
          m_vs = (m_row < VS);
          m_hr = (m_row >= VB) && (m_col < LB);
          m_px = ref_byte(m_mode, m_row, m_col);
          m_emit = 1; m_er = m_row; m_ec = m_col;
          if (m_row == TR - 1 && m_col == C - 1) begin
            m_fd = 1'b1; m_fc = m_fc + 16'd1; m_run = 0; m_row = 0; m_col = 0;
          end else if (m_col == C - 1) begin
            m_col = 0; m_row++;
          end else begin
            m_col++;
          end
        end
      end
    end
  endtask

  // One clk: sample after the edge, step model, compare every output
  task automatic cycle();
    @(negedge clk);
    model_step();
    chk("outputs{pclk,vs,href,px,fd,cnt}",
        {4'h0, CAM_PCLK, CAM_VSYNC, CAM_HREF, CAM_px_data, frame_done, frame_cnt},
        {4'h0, m_pclk, m_vs, m_hr, m_px, m_fd, m_fc});
    if (m_emit) cap[m_er][m_ec] = CAM_px_data;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_fd(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      if (frame_done === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_frame_done: no pulse within %0d clk", budget);
    end
  endtask

  task automatic go_idle();
    enable = 1'b0;
    if (m_run) wait_fd(FB);
    run(4 * PH);
  endtask

  task automatic run_frame(input int md);
    go_idle();
    mode   = 2'(md);
    enable = 1'b1;
    wait_fd(FB);
    enable = 1'b0;
    run(4 * PH);
  endtask

  typedef struct {
    int         md;
    int         r;
    int         c;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[20];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-derived expectations for the reduced geometry (LB=64, VB=4, BW=4)
    vt[0]  = '{0, 4, 0,  8'h0F};  vt[1]  = '{0, 6, 63, 8'h0F};
    vt[2]  = '{0, 4, 64, 8'h00};  vt[3]  = '{0, 2, 0,  8'h00};
    vt[4]  = '{1, 4, 0,  8'h0F};  vt[5]  = '{1, 4, 3,  8'h0F};
    vt[6]  = '{1, 4, 4,  8'hF0};  vt[7]  = '{1, 4, 7,  8'hF0};
    vt[8]  = '{1, 5, 8,  8'h0F};  vt[9]  = '{1, 5, 65, 8'h00};
    vt[10] = '{2, 4, 5,  8'h05};  vt[11] = '{2, 6, 63, 8'h3F};
    vt[12] = '{3, 4, 0,  8'h00};  vt[13] = '{3, 4, 1,  8'h00};
    vt[14] = '{3, 4, 8,  8'h00};  vt[15] = '{3, 4, 9,  8'h0F};
    vt[16] = '{3, 4, 17, 8'hF0};  vt[17] = '{3, 4, 32, 8'h0F};
    vt[18] = '{3, 4, 56, 8'h0F};  vt[19] = '{3, 4, 57, 8'hFF};

    // Reset held with enable low
    rst = 1'b1;
    run(20);
    chk("reset_outputs", {27'h0, CAM_PCLK, CAM_VSYNC, CAM_HREF, frame_done}, 32'h0);
    chk("reset_px", CAM_px_data, 8'h00);
    chk("reset_cnt", frame_cnt, 16'h0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      chk("pclk_div", CAM_PCLK, ((i / PH) % 2));
      chk("idle_href", CAM_HREF, 1'b0);
    end

    // Table-driven pattern checks, one frame per mode group
    for (int i = 0; i < 20; i++) begin
      if (i == 0 || vt[i].md != vt[i-1].md) run_frame(vt[i].md);
      chk($sformatf("table[%0d] m%0d r%0d c%0d", i, vt[i].md, vt[i].r, vt[i].c),
          cap[vt[i].r][vt[i].c], vt[i].exp);
    end
    chk("cnt_after_table", frame_cnt, 16'd4);

    // Mode change mid-frame takes effect only on the next frame
    go_idle();
    mode = 2'd0; enable = 1'b1;
    run(FRAME_CLK / 2);
    mode = 2'd2;
    wait_fd(FB);
    chk("mode_mid_frame_held", cap[6][10], 8'h0F);
    wait_fd(FB);
    chk("mode_next_frame", cap[4][5], 8'h05);

    // Dropping enable mid-frame lets the frame finish, then idles
    run(FRAME_CLK / 2);
    enable = 1'b0;
    wait_fd(FB);
    chk("drop_enable_cnt", frame_cnt, 16'd7);
    run(40);
    chk("idle_after_drop", {29'h0, CAM_HREF, CAM_VSYNC, frame_done}, 32'h0);

    // Reset mid-frame clears everything on the next clk
    mode = 2'd1; enable = 1'b1;
    for (int k = 0; k < FB && !(m_run && m_row == 5); k++) cycle();
    rst = 1'b1;
    cycle();
    chk("rst_mid_outputs", {20'h0, CAM_PCLK, CAM_VSYNC, CAM_HREF, CAM_px_data, frame_done}, 32'h0);
    chk("rst_mid_cnt", frame_cnt, 16'h0);
    rst = 1'b0; enable = 1'b0;
    run(8);

    // Frame counter wrap from 0xFFFF
    force dut.frame_cnt = 16'hFFFF;
    m_fc = 16'hFFFF;
    cycle();
    release dut.frame_cnt;
    run(2);
    mode = 2'd0; enable = 1'b1;
    wait_fd(FB);
    enable = 1'b0;
    chk("cnt_wrap", frame_cnt, 16'h0000);
    go_idle();

    // Random enable/mode/reset activity against the model
    for (int i = 0; i < 20000; i++) begin
      cycle();
      if (rst) begin
        rst = 1'b0;
      end else begin
        int r;
        r = $urandom_range(0, 999);
        if (r < 3)       enable = ~enable;
        else if (r < 8)  mode = 2'($urandom_range(0, 3));
        else if (r == 9 && $urandom_range(0, 3) == 0) rst = 1'b1;
      end
    end
    rst = 1'b0;
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_stim_gen.md
Name: cam_stim_gen

Overview:
Synthesizable, parametrised camera-side stimulus generator for the capture path. It emulates an OV7670-style byte stream: PCLK, VSYNC, HREF and 8-bit px_data. Frame geometry, blanking, PCLK rate and data pattern are configurable. It drives the CAM_* inputs of test_cam in simulation and on-board loopback, replacing hand-written bench loops.

Parameters:
LINE_BYTES, 320, active bytes per line (2 bytes per RGB444 pixel)
ROWS, 120, active lines per frame
H_BLANK, 4, blank byte slots after each line
V_BLANK, 4, blank lines at start of frame
VSYNC_ROWS, 2, lines with VSYNC high at frame start (must be < V_BLANK)
PCLK_HALF, 2, clk cycles per PCLK half-period (≥1)
CONST_VAL, 8'h0F, base byte for modes 0/1
BAR_W, 20, pixels per colour bar (mode 3)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  run frames; sampled only at frame boundary
mode  in  2  0 const, 1 toggle-4, 2 column counter, 3 RGB444 colour bars
CAM_PCLK  out  1  generated pixel clock (registered)
CAM_VSYNC  out  1  frame sync, active-high
CAM_HREF  out  1  line valid
CAM_px_data  out  8  pixel byte
frame_done  out  1  1-clk pulse at end of each frame
frame_cnt  out  16  completed frames, wraps at 0xFFFF→0

Behaviour:
- Reset: CAM_PCLK=0, VSYNC=0, HREF=0, px_data=0, frame_done=0, frame_cnt=0, div_cnt=0, col=0, row=0, state IDLE.
- Divider: div_cnt counts 0..PCLK_HALF-1; at PCLK_HALF-1 CAM_PCLK toggles, div_cnt→0. PCLK runs continuously after reset, in both IDLE and RUN. Period = 2*PCLK_HALF clk.
- All camera outputs update only on a "fall event": the clk where CAM_PCLK goes 1→0. Consumers sample on the PCLK rising edge with a half-period of setup.
- col range 0..LINE_BYTES+H_BLANK-1. row range 0..V_BLANK+ROWS-1.
- States:
  - IDLE: outputs 0, counters 0. At a fall event with enable=1: latch mode into mode_q, go to RUN, emit slot (row0,col0) on the same event.
  - RUN: each fall event registers outputs for the current (row,col), then col++.
    - At col wrap: col=0, row++.
    - At row wrap (last slot of frame): frame_done=1 for 1 clk, frame_cnt++.
    - Next slot: if enable=1, re-latch mode and continue at (0,0); else go to IDLE.
- Per-slot outputs:
  - VSYNC = (row < VSYNC_ROWS).
  - HREF = (row ≥ V_BLANK) && (col < LINE_BYTES).
  - px_data = 0 when HREF=0, else by mode_q:
    - mode 0: CONST_VAL.
    - mode 1: col[2] ? ~CONST_VAL : CONST_VAL.
    - mode 2: col[7:0].
    - mode 3: p = col>>1; bar = (p/BAR_W) mod 8; R = bar[2]?F:0, G = bar[1]?F:0, B = bar[0]?F:0. Even col → {4'h0,R}; odd col → {G,B}.
- mode and enable changes mid-frame have no effect until the next frame boundary.
- rst asserted mid-frame returns everything to reset values on the next clk; no partial frame_done.
- Counter widths: $clog2 of each range. Bar division uses a running pixel/bar counter, not a divider.

Decomposition:
- Package cam_stim_pkg: mode encodings (MODE_CONST, MODE_TOGGLE, MODE_COUNT, MODE_BARS), state enum {IDLE,RUN}, RGB444 colour-bar lookup function.
- One sub-module, cam_pattern_gen: registered byte generator taking col, HREF-qualified slot, mode_q and bar counter; produces px_data.
- Timing and counters stay in the top module.

Test Plan:
- rst=1 for 20 clk, enable=0 → CAM_PCLK toggles every 2 clk; VSYNC=HREF=px_data=0; frame_cnt=0.
- Defaults, enable=1, mode 0 → one frame = 324*124 = 40176 PCLK periods = 160704 clk; frame_done pulses once; HREF high for 320 PCLKs on each of rows 4..123; VSYNC high during rows 0..1; every HREF byte = 0x0F.
- mode 1 → on active lines, bytes for cols 0-3 = 0x0F, cols 4-7 = 0xF0, repeating; px_data=0 in cols 320..323.
- mode 3 → col0/1 = 0x00/0x00; col40/41 = 0x00/0x0F; col280/281 = 0x0F/0xFF.
- mode switched 0→2 mid-frame → rest of frame stays 0x0F; next frame col 5 reads 0x05. Drop enable mid-frame → current frame completes, frame_cnt increments, then IDLE.
- rst pulsed at row 60 → next clk all outputs 0, frame_cnt unchanged at 0. Separately, force frame_cnt to 0xFFFF → next frame_done wraps it to 0.
